md_write_dispatcher: RTL and testbench
======================================

MD_WRITE_DISPATCHER -- requirements
Module: md_write_dispatcher

Interface
REQ-001 SHALL have parameter SLV_AMT, default 2: number of slave-arbitration stages fed.
REQ-002 SHALL have parameter OUTSTANDING_AMT, default 8: depth of the write-order FIFO.
REQ-003 SHALL have parameters DATA_WIDTH 32, ADDR_WIDTH 32, TRANS_MST_ID_W 5, TRANS_BURST_W 2, TRANS_DATA_LEN_W 3, TRANS_DATA_SIZE_W 3: AXI field widths.
REQ-004 SHALL have parameters SLV_ID_MSB_IDX 30, SLV_ID_LSB_IDX 30 and SLV_ID_W = $clog2(SLV_AMT): address slice selecting the slave; slice width equals SLV_ID_W.
REQ-005 SHALL have ports ACLK_i in 1 (clock) and ARESETn_i in 1; one clock; reset asynchronous, active-low.
REQ-006 SHALL have master AW inputs m_AWID_i, m_AWADDR_i, m_AWBURST_i, m_AWLEN_i, m_AWSIZE_i (parameter widths) and m_AWVALID_i in 1, plus m_AWREADY_o out 1.
REQ-007 SHALL have master W inputs m_WDATA_i in DATA_WIDTH, m_WLAST_i in 1, m_WVALID_i in 1, plus m_WREADY_o out 1.
REQ-008 SHALL have per-slave AW outputs sa_AWID_o, sa_AWADDR_o, sa_AWBURST_o, sa_AWLEN_o, sa_AWSIZE_o (field width x SLV_AMT), sa_AWVALID_o out SLV_AMT, sa_AW_outst_full_o out SLV_AMT, and sa_AWREADY_i in SLV_AMT.
REQ-009 SHALL have per-slave W outputs sa_WDATA_o out DATA_WIDTH*SLV_AMT, sa_WLAST_o out SLV_AMT, sa_WVALID_o out SLV_AMT, sa_slv_sel_o out SLV_AMT, and sa_WREADY_i in SLV_AMT.

Function
REQ-010 SHALL decode slv = m_AWADDR_i[SLV_ID_MSB_IDX:SLV_ID_LSB_IDX] combinationally.
REQ-011 SHALL broadcast all master AW fields unchanged to every slave slot; sa_AWVALID_o[k] = m_AWVALID_i & (slv==k) & ~full.
REQ-012 SHALL drive m_AWREADY_o = sa_AWREADY_i[slv] & ~full & (slv<SLV_AMT); a decoded slv >= SLV_AMT is never issued and AWREADY stays 0.
REQ-013 SHALL push slv into the order FIFO on every AW handshake (m_AWVALID_i & m_AWREADY_o).
REQ-014 SHALL hold a registered occupancy count 0..OUTSTANDING_AMT; full = (count==OUTSTANDING_AMT), empty = (count==0); read/write pointers wrap modulo OUTSTANDING_AMT.
REQ-015 SHALL drive every bit of sa_AW_outst_full_o = full.
REQ-016 SHALL route W beats to head = FIFO head entry: sa_WVALID_o[k] = m_WVALID_i & ~empty & (head==k); m_WREADY_o = sa_WREADY_i[head] & ~empty.
REQ-017 SHALL broadcast m_WDATA_i and m_WLAST_i to every slave slot.
REQ-018 SHALL drive sa_slv_sel_o one-hot at head when ~empty, all-zero when empty.
REQ-019 SHALL pop the FIFO on a W handshake with m_WLAST_i=1; non-last beats do not pop.
REQ-020 SHALL apply simultaneous push and pop in the same cycle: count unchanged, both pointers advance.
REQ-021 SHALL block a push while full even if a pop occurs that cycle (full from registered count).
REQ-022 SHALL provide no empty-FIFO bypass: W for an AW accepted in cycle N is forwarded no earlier than cycle N+1.
REQ-023 SHALL hold W ordering strictly to AW acceptance order, regardless of slave.

Reset
REQ-024 SHALL on ARESETn_i=0, asynchronously clear count and both pointers; outputs then: m_AWREADY_o per REQ-012 with full=0, m_WREADY_o=0, sa_WVALID_o=0, sa_slv_sel_o=0, sa_AW_outst_full_o=0.
REQ-025 SHALL on reset mid-burst discard all pending order entries; post-reset W beats are stalled until a new AW is accepted.

Verification
REQ-026 Single write: AW addr 0x4000_0000 (slv 1), LEN=3, sa_AWREADY_i=2'b11 -> sa_AWVALID_o=2'b10 same cycle; next cycle sa_slv_sel_o=2'b10; 4 W beats appear only on slot 1; count returns 0 after WLAST.
REQ-027 Ordering: AW to slv0 then slv1, W valid held -> all beats of burst 1 on slot 0, then slot 1; sa_slv_sel_o 01 -> 10 in the cycle after WLAST handshake.
REQ-028 Full: 8 AWs accepted, no W -> sa_AW_outst_full_o all 1, m_AWREADY_o=0 on 9th AW; one WLAST pop -> AWREADY reasserts next cycle.
REQ-029 Simultaneous push/pop at count=3 -> count stays 3, pointers advance, no lost entry.
REQ-030 Backpressure: sa_WREADY_i[head]=0 -> m_WREADY_o=0, beat held; early W before any AW -> m_WREADY_o=0, sa_WVALID_o=0.
REQ-031 Reset asserted mid-burst at count=2 -> count 0, sa_slv_sel_o=0 immediately; next AW restarts normal routing.

Source files
------------

// File: rtl/md_write_dispatcher.sv
// Routes master AW requests to the slave selected by an address slice and steers
// W beats to slaves in strict AW-acceptance order via a small order FIFO.
module md_write_dispatcher #(
  parameter int SLV_AMT           = 2,
  parameter int OUTSTANDING_AMT   = 8,
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 32,
  parameter int TRANS_MST_ID_W    = 5,
  parameter int TRANS_BURST_W     = 2,
  parameter int TRANS_DATA_LEN_W  = 3,
  parameter int TRANS_DATA_SIZE_W = 3,
  parameter int SLV_ID_MSB_IDX    = 30,
  parameter int SLV_ID_LSB_IDX    = 30,
  parameter int SLV_ID_W          = $clog2(SLV_AMT)
) (
  input  logic                                    ACLK_i,
  input  logic                                    ARESETn_i,
  input  logic [TRANS_MST_ID_W-1:0]               m_AWID_i,
  input  logic [ADDR_WIDTH-1:0]                   m_AWADDR_i,
  input  logic [TRANS_BURST_W-1:0]                m_AWBURST_i,
  input  logic [TRANS_DATA_LEN_W-1:0]             m_AWLEN_i,
  input  logic [TRANS_DATA_SIZE_W-1:0]            m_AWSIZE_i,
  input  logic                                    m_AWVALID_i,
  output logic                                    m_AWREADY_o,
  input  logic [DATA_WIDTH-1:0]                   m_WDATA_i,
  input  logic                                    m_WLAST_i,
  input  logic                                    m_WVALID_i,
  output logic                                    m_WREADY_o,
  output logic [TRANS_MST_ID_W*SLV_AMT-1:0]       sa_AWID_o,
  output logic [ADDR_WIDTH*SLV_AMT-1:0]           sa_AWADDR_o,
  output logic [TRANS_BURST_W*SLV_AMT-1:0]        sa_AWBURST_o,
  output logic [TRANS_DATA_LEN_W*SLV_AMT-1:0]     sa_AWLEN_o,
  output logic [TRANS_DATA_SIZE_W*SLV_AMT-1:0]    sa_AWSIZE_o,
  output logic [SLV_AMT-1:0]                      sa_AWVALID_o,
  output logic [SLV_AMT-1:0]                      sa_AW_outst_full_o,
  input  logic [SLV_AMT-1:0]                      sa_AWREADY_i,
  output logic [DATA_WIDTH*SLV_AMT-1:0]           sa_WDATA_o,
  output logic [SLV_AMT-1:0]                      sa_WLAST_o,
  output logic [SLV_AMT-1:0]                      sa_WVALID_o,
  output logic [SLV_AMT-1:0]                      sa_slv_sel_o,
  input  logic [SLV_AMT-1:0]                      sa_WREADY_i
);

  localparam int PTR_W = (OUTSTANDING_AMT > 1) ? $clog2(OUTSTANDING_AMT) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING_AMT + 1);

  // Handshake rule on every channel: a transfer happens in a cycle where valid
  // and ready are both high; valid never waits on ready.
  logic [SLV_ID_W-1:0] slv;
  logic [SLV_ID_W-1:0] head;
  logic                slv_ok;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [SLV_ID_W-1:0] order_mem [OUTSTANDING_AMT];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING_AMT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign slv    = m_AWADDR_i[SLV_ID_MSB_IDX:SLV_ID_LSB_IDX];
  assign slv_ok = ({1'b0, slv} < (SLV_ID_W + 1)'(SLV_AMT));
  assign full   = (count == CNT_W'(OUTSTANDING_AMT));
  assign empty  = (count == '0);
  assign head   = order_mem[rd_ptr];

  assign m_AWREADY_o = slv_ok & ~full & sa_AWREADY_i[slv];
  assign m_WREADY_o  = ~empty & sa_WREADY_i[head];
  assign push        = m_AWVALID_i & m_AWREADY_o;
  assign pop         = m_WVALID_i & m_WREADY_o & m_WLAST_i;

  assign sa_AWID_o          = {SLV_AMT{m_AWID_i}};
  assign sa_AWADDR_o        = {SLV_AMT{m_AWADDR_i}};
  assign sa_AWBURST_o       = {SLV_AMT{m_AWBURST_i}};
  assign sa_AWLEN_o         = {SLV_AMT{m_AWLEN_i}};
  assign sa_AWSIZE_o        = {SLV_AMT{m_AWSIZE_i}};
  assign sa_WDATA_o         = {SLV_AMT{m_WDATA_i}};
  assign sa_WLAST_o         = {SLV_AMT{m_WLAST_i}};
  assign sa_AW_outst_full_o = {SLV_AMT{full}};

  for (genvar k = 0; k < SLV_AMT; k++) begin : g_slot
    assign sa_AWVALID_o[k] = m_AWVALID_i & slv_ok & (slv == SLV_ID_W'(k)) & ~full;
    assign sa_slv_sel_o[k] = ~empty & (head == SLV_ID_W'(k));
    assign sa_WVALID_o[k]  = m_WVALID_i & sa_slv_sel_o[k];
  end

  // Order entries need no reset: they are only read while count is non-zero.
  always_ff @(posedge ACLK_i) begin
    if (push) order_mem[wr_ptr] <= slv;
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_md_write_dispatcher.sv
// Bench for md_write_dispatcher: a directed vector table, then model-checked
// sequences for full, push/pop, reset and random traffic.
module tb_md_write_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  aw_id;
  logic [31:0] aw_addr;
  logic [1:0]  aw_burst;
  logic [2:0]  aw_len;
  logic [2:0]  aw_size;
  logic        aw_valid;
  logic [31:0] w_data;
  logic        w_last;
  logic        w_valid;
  logic [1:0]  aw_rdy;
  logic [1:0]  w_rdy;

  logic        m_AWREADY_o;
  logic        m_WREADY_o;
  logic [9:0]  sa_AWID_o;
  logic [63:0] sa_AWADDR_o;
  logic [3:0]  sa_AWBURST_o;
  logic [5:0]  sa_AWLEN_o;
  logic [5:0]  sa_AWSIZE_o;
  logic [1:0]  sa_AWVALID_o;
  logic [1:0]  sa_AW_outst_full_o;
  logic [63:0] sa_WDATA_o;
  logic [1:0]  sa_WLAST_o;
  logic [1:0]  sa_WVALID_o;
  logic [1:0]  sa_slv_sel_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected slave order of accepted AWs, oldest first.
  logic [0:0] exp_q[$];

  logic       m_awr, m_wr, m_full;
  logic [1:0] m_awv, m_wv, m_sel;
  logic [0:0] m_slv;

  md_write_dispatcher dut (
    .ACLK_i             (clk),
    .ARESETn_i          (rst_n),
    .m_AWID_i           (aw_id),
    .m_AWADDR_i         (aw_addr),
    .m_AWBURST_i        (aw_burst),
    .m_AWLEN_i          (aw_len),
    .m_AWSIZE_i         (aw_size),
    .m_AWVALID_i        (aw_valid),
    .m_AWREADY_o        (m_AWREADY_o),
    .m_WDATA_i          (w_data),
    .m_WLAST_i          (w_last),
    .m_WVALID_i         (w_valid),
    .m_WREADY_o         (m_WREADY_o),
    .sa_AWID_o          (sa_AWID_o),
    .sa_AWADDR_o        (sa_AWADDR_o),
    .sa_AWBURST_o       (sa_AWBURST_o),
    .sa_AWLEN_o         (sa_AWLEN_o),
    .sa_AWSIZE_o        (sa_AWSIZE_o),
    .sa_AWVALID_o       (sa_AWVALID_o),
    .sa_AW_outst_full_o (sa_AW_outst_full_o),
    .sa_AWREADY_i       (aw_rdy),
    .sa_WDATA_o         (sa_WDATA_o),
    .sa_WLAST_o         (sa_WLAST_o),
    .sa_WVALID_o        (sa_WVALID_o),
    .sa_slv_sel_o       (sa_slv_sel_o),
    .sa_WREADY_i        (w_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_aw(input logic v, input logic s, input logic [1:0] rdy);
    aw_valid = v;
    aw_addr  = {1'b0, s, 30'($urandom)};
    aw_id    = 5'($urandom);
    aw_burst = 2'($urandom);
    aw_len   = 3'($urandom);
    aw_size  = 3'($urandom);
    aw_rdy   = rdy;
  endtask

  task automatic set_w(input logic v, input logic l, input logic [1:0] rdy);
    w_valid = v;
    w_last  = l;
    w_data  = $urandom;
    w_rdy   = rdy;
  endtask

  // Called just after a rising edge: settle, then compute expected outputs.
  task automatic eval_model();
    logic       empty;
    logic [0:0] hd;
    #3;
    m_slv  = aw_addr[30];
    m_full = (exp_q.size() == 8);
    empty  = (exp_q.size() == 0);
    hd     = empty ? 1'b0 : exp_q[0];
    m_awr  = !m_full && aw_rdy[m_slv];
    m_awv  = (aw_valid && !m_full) ? (2'b01 << m_slv) : 2'b00;
    m_wr   = !empty && w_rdy[hd];
    m_sel  = empty ? 2'b00 : (2'b01 << hd);
    m_wv   = w_valid ? m_sel : 2'b00;
  endtask

  task automatic check_bcast();
    check("bcast_awaddr", sa_AWADDR_o, {2{aw_addr}});
    check("bcast_awid",   {54'd0, sa_AWID_o, sa_AWBURST_o, sa_AWLEN_o, sa_AWSIZE_o},
          {54'd0, {2{aw_id}}, {2{aw_burst}}, {2{aw_len}}, {2{aw_size}}});
    check("bcast_wdata",  sa_WDATA_o, {2{w_data}});
    check("bcast_wlast",  sa_WLAST_o, {2{w_last}});
  endtask

  task automatic check_model(input string tag);
    check({tag, "_awready"},  m_AWREADY_o, m_awr);
    check({tag, "_awvalid"},  sa_AWVALID_o, m_awv);
    check({tag, "_wready"},   m_WREADY_o, m_wr);
    check({tag, "_wvalid"},   sa_WVALID_o, m_wv);
    check({tag, "_sel"},      sa_slv_sel_o, m_sel);
    check({tag, "_outst"},    sa_AW_outst_full_o, {2{m_full}});
  endtask

  task automatic advance();
    @(posedge clk);
    if (w_valid && m_wr && w_last) void'(exp_q.pop_front());
    if (aw_valid && m_awr) exp_q.push_back(m_slv);
    #1;
  endtask

  task automatic model_cycle(input string tag);
    eval_model();
    check_model(tag);
    advance();
  endtask

  typedef struct {
    logic       awv;
    logic       s;
    logic [1:0] awr;
    logic       wv;
    logic       wl;
    logic [1:0] wr;
    logic       e_awready;
    logic [1:0] e_awvalid;
    logic       e_wready;
    logic [1:0] e_wvalid;
    logic [1:0] e_sel;
    logic       e_full;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 2'b00, 1'b1, 2'b10, 2'b10, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 2'b10, 2'b10, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 2'b00, 1'b1, 2'b10, 2'b10, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 2'b11, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 2'b11, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 2'b10, 1'b1, 2'b01, 2'b01, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 2'b00, 1'b1, 2'b10, 2'b10, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 2'b00, 1'b1, 2'b10, 2'b10, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0};

    // Reset state
    rst_n = 1'b0;
    set_aw(1'b0, 1'b0, 2'b11);
    set_w(1'b0, 1'b0, 2'b11);
    #2;
    check("rst_awready", m_AWREADY_o, 1'b1);
    check("rst_wready",  m_WREADY_o, 1'b0);
    check("rst_wvalid",  sa_WVALID_o, 2'b00);
    check("rst_sel",     sa_slv_sel_o, 2'b00);
    check("rst_outst",   sa_AW_outst_full_o, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: single write, backpressure, early W, push+pop, ordering
    for (int i = 0; i < 12; i++) begin
      set_aw(vecs[i].awv, vecs[i].s, vecs[i].awr);
      set_w(vecs[i].wv, vecs[i].wl, vecs[i].wr);
      eval_model();
      check($sformatf("vec%0d_awready", i), m_AWREADY_o, vecs[i].e_awready);
      check($sformatf("vec%0d_awvalid", i), sa_AWVALID_o, vecs[i].e_awvalid);
      check($sformatf("vec%0d_wready", i),  m_WREADY_o, vecs[i].e_wready);
      check($sformatf("vec%0d_wvalid", i),  sa_WVALID_o, vecs[i].e_wvalid);
      check($sformatf("vec%0d_sel", i),     sa_slv_sel_o, vecs[i].e_sel);
      check($sformatf("vec%0d_outst", i),   sa_AW_outst_full_o, {2{vecs[i].e_full}});
      check_bcast();
      advance();
    end

    // Fill to capacity with no W traffic
    set_w(1'b0, 1'b0, 2'b11);
    for (int i = 0; i < 8; i++) begin
      set_aw(1'b1, 1'(i), 2'b11);
      model_cycle("fill");
    end
    set_aw(1'b1, 1'b0, 2'b11);
    eval_model();
    check("full_outst", sa_AW_outst_full_o, 2'b11);
    check("full_9th_awready", m_AWREADY_o, 1'b0);
    check("full_9th_awvalid", sa_AWVALID_o, 2'b00);
    advance();
    // Pop while full: the push stays blocked this cycle
    set_w(1'b1, 1'b1, 2'b11);
    eval_model();
    check("full_pop_awready", m_AWREADY_o, 1'b0);
    check("full_pop_wready", m_WREADY_o, 1'b1);
    check("full_pop_sel", sa_slv_sel_o, 2'b01);
    advance();
    set_w(1'b0, 1'b0, 2'b11);
    eval_model();
    check("full_reassert_awready", m_AWREADY_o, 1'b1);
    check("full_reassert_outst", sa_AW_outst_full_o, 2'b00);
    check_model("after_full");
    advance();
    set_aw(1'b0, 1'b0, 2'b11);
    set_w(1'b1, 1'b1, 2'b11);
    for (int i = 0; i < 9; i++) model_cycle("drain");
    check("drain_sel", sa_slv_sel_o, 2'b00);

    // Simultaneous push and pop at three outstanding
    set_w(1'b0, 1'b0, 2'b11);
    set_aw(1'b1, 1'b1, 2'b11); model_cycle("pp_fill");
    set_aw(1'b1, 1'b0, 2'b11); model_cycle("pp_fill");
    set_aw(1'b1, 1'b1, 2'b11); model_cycle("pp_fill");
    set_aw(1'b1, 1'b0, 2'b11);
    set_w(1'b1, 1'b1, 2'b11);
    eval_model();
    check("pp_sel_before", sa_slv_sel_o, 2'b10);
    check("pp_awready", m_AWREADY_o, 1'b1);
    check("pp_wready", m_WREADY_o, 1'b1);
    advance();
    set_aw(1'b0, 1'b0, 2'b11);
    set_w(1'b0, 1'b0, 2'b11);
    eval_model();
    check("pp_sel_after", sa_slv_sel_o, 2'b01);
    advance();
    set_w(1'b1, 1'b1, 2'b11);
    for (int i = 0; i < 4; i++) model_cycle("pp_drain");

    // Reset in the middle of a burst with two entries outstanding
    set_w(1'b0, 1'b0, 2'b11);
    set_aw(1'b1, 1'b1, 2'b11); model_cycle("rb_fill");
    set_aw(1'b1, 1'b0, 2'b11); model_cycle("rb_fill");
    set_aw(1'b0, 1'b0, 2'b11);
    set_w(1'b1, 1'b0, 2'b11);
    model_cycle("rb_beat");
    #1;
    rst_n = 1'b0;
    #1;
    check("rb_sel", sa_slv_sel_o, 2'b00);
    check("rb_wvalid", sa_WVALID_o, 2'b00);
    check("rb_wready", m_WREADY_o, 1'b0);
    check("rb_outst", sa_AW_outst_full_o, 2'b00);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_cycle("rb_stall");
    set_aw(1'b1, 1'b0, 2'b11);
    model_cycle("rb_new_aw");
    set_aw(1'b0, 1'b0, 2'b11);
    set_w(1'b1, 1'b1, 2'b11);
    eval_model();
    check("rb_route_sel", sa_slv_sel_o, 2'b01);
    check("rb_route_wvalid", sa_WVALID_o, 2'b01);
    advance();

    // Random traffic against the order model
    for (int i = 0; i < 400; i++) begin
      set_aw(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      set_w(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));
      eval_model();
      check_model("rnd");
      check_bcast();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
